// File: rtl/video_pll_reconfig.sv
// Runtime PLL ratio reconfiguration and lock supervisor.
// Sequences PLL reset, qualifies lock with a stable-count window, retries on
// timeout and gates output clocks until lock is confirmed.
// Optional feature: define VIDEO_PLL_LOCK_MON_EN to auto-relock on loss of lock in RUN.
module video_pll_reconfig #(
    parameter int unsigned NUM_OUT       = 4,
    parameter int unsigned RATIO_W       = 10,
    parameter int unsigned DEF_IDIV      = 7,
    parameter int unsigned DEF_FDIV      = 156,
    parameter logic [NUM_OUT*RATIO_W-1:0] DEF_ODIV = {10'd124, 10'd46, 10'd15, 10'd3},
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_WAIT     = 100000,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [RATIO_W-1:0]         cfg_idiv,
    input  logic [RATIO_W-1:0]         cfg_fdiv,
    input  logic [NUM_OUT*RATIO_W-1:0] cfg_odiv,
    input  logic                       pll_lock,
    output logic                       pll_rst,
    output logic [RATIO_W-1:0]         pll_ratioi,
    output logic [RATIO_W-1:0]         pll_ratiof,
    output logic [NUM_OUT*RATIO_W-1:0] pll_odiv,
    output logic [NUM_OUT*RATIO_W-1:0] pll_duty,
    output logic [NUM_OUT-1:0]         clk_en,
    output logic                       locked,
    output logic                       err,
    output logic [3:0]                 retry_cnt
);

    localparam int unsigned CntMax = (RST_CYCLES > LOCK_WAIT) ? RST_CYCLES : LOCK_WAIT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned StabW  = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {StAssertRst, StWaitLock, StRun, StFail} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [StabW-1:0]           stab_q, stab_d;
    logic [3:0]                 retry_q, retry_d, retry_inc;
    logic                       err_q, err_d;
    logic [RATIO_W-1:0]         idiv_q, idiv_d, fdiv_q, fdiv_d;
    logic [NUM_OUT*RATIO_W-1:0] odiv_q, odiv_d;
    logic                       pll_rst_q, pll_rst_d;
    logic                       run_q, run_d;
    logic                       cfg_ready_q, cfg_ready_d;
    logic                       sync1_q, lock_s_q;
    logic                       handshake, stable_done, timeout;
`ifdef VIDEO_PLL_LOCK_MON_EN
    logic                       low_q, low_d;
`endif

    // Lock synchroniser; held clear while the PLL is in reset so a stale lock
    // from the previous configuration never counts toward the stable window.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else if (pll_rst_q) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Next-state, counters, ratio capture and registered output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stab_d    = stab_q;
        retry_d   = retry_q;
        err_d     = err_q;
        idiv_d    = idiv_q;
        fdiv_d    = fdiv_q;
        odiv_d    = odiv_q;
`ifdef VIDEO_PLL_LOCK_MON_EN
        low_d     = 1'b0;
`endif
        handshake   = cfg_valid && cfg_ready_q;
        stable_done = lock_s_q && (stab_q == StabW'(STABLE_CYCLES - 1));
        timeout     = (cnt_q == CntW'(LOCK_WAIT - 1));
        retry_inc   = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

        unique case (state_q)
            StAssertRst: begin
                if (cnt_q == CntW'(RST_CYCLES - 1)) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (!lock_s_q)          stab_d = '0;
                else if (stab_q != '1)  stab_d = stab_q + 1'b1;
                // Stable completion takes priority over a coincident timeout.
                if (stable_done) begin
                    state_d = StRun;
                    retry_d = 4'd0;
                    cnt_d   = '0;
                end else if (timeout) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    if (retry_inc < 4'(MAX_RETRY)) begin
                        state_d = StAssertRst;
                    end else begin
                        state_d = StFail;
                        err_d   = 1'b1;
                    end
                end
            end
            StRun: begin
`ifdef VIDEO_PLL_LOCK_MON_EN
                // Two consecutive low samples of lock_s trigger a relock.
                low_d = !lock_s_q;
                if (!lock_s_q && low_q) begin
                    state_d = StAssertRst;
                    cnt_d   = '0;
                    retry_d = 4'd0;
                end
`endif
            end
            StFail: begin
            end
            default: state_d = StAssertRst;
        endcase

        // Handshake only possible in RUN/FAIL; new ratios land together with pll_rst.
        if (handshake) begin
            idiv_d  = cfg_idiv;
            fdiv_d  = cfg_fdiv;
            odiv_d  = cfg_odiv;
            err_d   = 1'b0;
            retry_d = 4'd0;
            cnt_d   = '0;
            state_d = StAssertRst;
        end

        pll_rst_d   = (state_d == StAssertRst) || (state_d == StFail);
        run_d       = (state_d == StRun);
        cfg_ready_d = (state_d == StRun) || (state_d == StFail);
    end

    // State, counters, ratios and glitch-free registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAssertRst;
            cnt_q       <= '0;
            stab_q      <= '0;
            retry_q     <= 4'd0;
            err_q       <= 1'b0;
            idiv_q      <= RATIO_W'(DEF_IDIV);
            fdiv_q      <= RATIO_W'(DEF_FDIV);
            odiv_q      <= DEF_ODIV;
            pll_rst_q   <= 1'b1;
            run_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            idiv_q      <= idiv_d;
            fdiv_q      <= fdiv_d;
            odiv_q      <= odiv_d;
            pll_rst_q   <= pll_rst_d;
            run_q       <= run_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

`ifdef VIDEO_PLL_LOCK_MON_EN
    // Remembers a low lock_s sample from the previous RUN cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) low_q <= 1'b0;
        else        low_q <= low_d;
    end
`endif

    assign cfg_ready  = cfg_ready_q;
    assign pll_rst    = pll_rst_q;
    assign pll_ratioi = idiv_q;
    assign pll_ratiof = fdiv_q;
    assign pll_odiv   = odiv_q;
    assign pll_duty   = odiv_q;
    assign clk_en     = {NUM_OUT{run_q}};
    assign locked     = run_q;
    assign err        = err_q;
    assign retry_cnt  = retry_q;

endmodule
